// File: rtl/spi_flash_slave_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, FSM states and status layout.
package spi_flash_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RDATA,
    ST_PDATA,
    ST_STAT,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;

  localparam int SR_WIP_BIT = 0;
  localparam int SR_WEL_BIT = 1;

  // Write-in-progress never sets: programming completes within the byte.
  function automatic logic [7:0] status_byte(input logic wel);
    logic [7:0] sr;
    sr             = 8'h00;
    sr[SR_WIP_BIT] = 1'b0;
    sr[SR_WEL_BIT] = wel;
    return sr;
  endfunction

endpackage

// File: rtl/spi_flash_slave_if.sv
// SPI pin bundle between a flash master and the flash responder.
interface spi_flash_slave_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, input miso);
  modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizers for the asynchronous SPI pins plus SCLK and CS edge pulses.
module spi_slave_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sclk,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_cs_rise,
  output logic o_cs_fall,
  output logic o_cs_n,
  output logic o_mosi
);

  // Bit 0 and 1 form the synchronizer, bit 2 is the previous synced value.
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], i_sclk};
      cs_q   <= {cs_q[1:0], i_cs_n};
      mosi_q <= {mosi_q[0], i_mosi};
    end
  end

  assign o_sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign o_sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign o_cs_rise   = cs_q[1] & ~cs_q[2];
  assign o_cs_fall   = ~cs_q[1] & cs_q[2];
  assign o_cs_n      = cs_q[1];
  assign o_mosi      = mosi_q[1];

endmodule

// File: rtl/spi_flash_slave.sv
// SPI mode-0 flash responder: WREN/WRDI/RDSR/READ/PP decode serving a small byte memory.
module spi_flash_slave
  import spi_flash_slave_pkg::*;
#(
  parameter int P_MEM_DEPTH  = 256,
  parameter int P_ADDR_BYTES = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  spi_flash_slave_if.slave   spi,
  output logic [7:0]         o_cmd,
  output logic               o_cmd_valid,
  output logic               o_wel,
  output logic               o_prog_valid,
  output logic [7:0]         o_prog_addr,
  output logic [7:0]         o_prog_data
);

  localparam int AW        = $clog2(P_MEM_DEPTH);
  localparam int ADDR_BITS = 8 * P_ADDR_BYTES;
  localparam int ACW       = $clog2(ADDR_BITS);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_n, mosi;

  spi_slave_sync u_sync (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sclk      (spi.sclk),
    .i_cs_n      (spi.cs_n),
    .i_mosi      (spi.mosi),
    .o_sclk_rise (sclk_rise),
    .o_sclk_fall (sclk_fall),
    .o_cs_rise   (cs_rise),
    .o_cs_fall   (cs_fall),
    .o_cs_n      (cs_n),
    .o_mosi      (mosi)
  );

  logic [7:0]     mem [P_MEM_DEPTH];

  state_t         state_q;
  logic [2:0]     bit_cnt_q;
  logic [ACW-1:0] addr_cnt_q;
  logic [AW-1:0]  addr_q;
  logic [7:0]     rx_q;
  logic [7:0]     tx_q;
  logic [7:0]     cmd_q;
  logic           cmd_valid_q;
  logic           wel_q;
  logic           pp_wel_q;
  logic           is_read_q;
  logic           miso_q;
  logic           prog_valid_q;
  logic [7:0]     prog_addr_q;
  logic [7:0]     prog_data_q;

  logic [7:0]     rx_d;
  logic [AW-1:0]  addr_d;
  logic           mem_we;

  always_comb begin
    rx_d   = {rx_q[6:0], mosi};
    addr_d = {addr_q[AW-2:0], mosi};
    // Synced CS high blocks the write even when the 8th rise lands in the same cycle.
    mem_we = (state_q == ST_PDATA) && sclk_rise && (bit_cnt_q == 3'd7) && !cs_n;
  end

  always_ff @(posedge i_clk) begin
    if (sclk_rise) rx_q <= rx_d;
    if (mem_we)    mem[addr_q] <= rx_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      addr_cnt_q   <= '0;
      cmd_q        <= 8'h00;
      cmd_valid_q  <= 1'b0;
      wel_q        <= 1'b0;
      pp_wel_q     <= 1'b0;
      is_read_q    <= 1'b0;
      miso_q       <= 1'b0;
      prog_valid_q <= 1'b0;
      prog_addr_q  <= 8'h00;
      prog_data_q  <= 8'h00;
    end else begin
      cmd_valid_q  <= 1'b0;
      prog_valid_q <= 1'b0;
      if (cs_n) begin
        state_q    <= ST_IDLE;
        bit_cnt_q  <= 3'd0;
        addr_cnt_q <= '0;
        miso_q     <= 1'b0;
        // A PP that started with the latch set always consumes it at CS release.
        if (cs_rise && pp_wel_q) begin
          wel_q    <= 1'b0;
          pp_wel_q <= 1'b0;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (cs_fall) state_q <= ST_CMD;
          end
          ST_CMD: begin
            if (sclk_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                cmd_q       <= rx_d;
                cmd_valid_q <= 1'b1;
                is_read_q   <= (rx_d == OP_READ);
                case (rx_d)
                  OP_WREN: begin
                    wel_q   <= 1'b1;
                    state_q <= ST_IGNORE;
                  end
                  OP_WRDI: begin
                    wel_q   <= 1'b0;
                    state_q <= ST_IGNORE;
                  end
                  OP_RDSR: begin
                    tx_q    <= status_byte(wel_q);
                    state_q <= ST_STAT;
                  end
                  OP_READ: state_q <= ST_ADDR;
                  OP_PP: begin
                    if (wel_q) begin
                      pp_wel_q <= 1'b1;
                      state_q  <= ST_ADDR;
                    end else begin
                      state_q  <= ST_IGNORE;
                    end
                  end
                  default: state_q <= ST_IGNORE;
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise) begin
              addr_q     <= addr_d;
              addr_cnt_q <= addr_cnt_q + 1'b1;
              if (addr_cnt_q == ACW'(ADDR_BITS - 1)) begin
                bit_cnt_q <= 3'd0;
                if (is_read_q) begin
                  tx_q    <= mem[addr_d];
                  state_q <= ST_RDATA;
                end else begin
                  state_q <= ST_PDATA;
                end
              end
            end
          end
          ST_RDATA: begin
            if (sclk_fall) begin
              miso_q    <= tx_q[7];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                addr_q <= addr_q + 1'b1;
                tx_q   <= mem[addr_q + 1'b1];
              end else begin
                tx_q   <= {tx_q[6:0], 1'b0};
              end
            end
          end
          ST_STAT: begin
            if (sclk_fall) begin
              miso_q    <= tx_q[7];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= (bit_cnt_q == 3'd7) ? status_byte(wel_q) : {tx_q[6:0], 1'b0};
            end
          end
          ST_PDATA: begin
            if (sclk_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                prog_valid_q <= 1'b1;
                prog_addr_q  <= 8'(addr_q);
                prog_data_q  <= rx_d;
                addr_q       <= addr_q + 1'b1;
              end
            end
          end
          ST_IGNORE: miso_q <= 1'b0;
          default:   state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi.miso     = miso_q;
  assign o_cmd        = cmd_q;
  assign o_cmd_valid  = cmd_valid_q;
  assign o_wel        = wel_q;
  assign o_prog_valid = prog_valid_q;
  assign o_prog_addr  = prog_addr_q;
  assign o_prog_data  = prog_data_q;

endmodule

// File: tb/tb_spi_flash_slave.sv
// Scoreboard bench for spi_flash_slave: SCLK at clk/8, expected bytes queued ahead of the bus traffic.
module tb_spi_flash_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       wel;
  logic       prog_valid;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;

  spi_flash_slave_if spi ();

  spi_flash_slave #(.P_MEM_DEPTH(256), .P_ADDR_BYTES(3)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .spi          (spi),
    .o_cmd        (cmd),
    .o_cmd_valid  (cmd_valid),
    .o_wel        (wel),
    .o_prog_valid (prog_valid),
    .o_prog_addr  (prog_addr),
    .o_prog_data  (prog_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] prog_q[$];
  logic [7:0]  rd_q[$];
  int          cmd_cnt = 0;
  logic [7:0]  last_cmd = 8'h00;

  always @(negedge clk) begin
    logic [15:0] exp_p;
    if (cmd_valid) begin
      cmd_cnt++;
      last_cmd = cmd;
    end
    if (prog_valid) begin
      checks++;
      if (prog_q.size() == 0) begin
        errors++;
        $display("FAIL prog_unexpected: got addr=%h data=%h, required no pulse", prog_addr, prog_data);
      end else begin
        exp_p = prog_q.pop_front();
        if ({prog_addr, prog_data} !== exp_p) begin
          errors++;
          $display("FAIL prog_pulse: got addr=%h data=%h, required addr=%h data=%h",
                   prog_addr, prog_data, exp_p[15:8], exp_p[7:0]);
        end
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time budget expired");
    $fatal(1, "watchdog");
  end

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi.mosi = tx[i];
      #40;
      spi.sclk = 1'b1;
      rx[i] = spi.miso;
      #40;
      spi.sclk = 1'b0;
    end
  endtask

  task automatic spi_begin();
    spi.cs_n = 1'b0;
    #40;
  endtask

  task automatic spi_end();
    #40;
    spi.cs_n = 1'b1;
    spi.mosi = 1'b0;
    #120;
  endtask

  task automatic do_cmd(input logic [7:0] op);
    logic [7:0] rx;
    spi_begin();
    spi_bits(op, 8, rx);
    spi_end();
  endtask

  task automatic do_pp(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1, input int n);
    logic [7:0] rx;
    spi_begin();
    spi_bits(8'h02, 8, rx);
    spi_bits(a[23:16], 8, rx);
    spi_bits(a[15:8], 8, rx);
    spi_bits(a[7:0], 8, rx);
    spi_bits(d0, 8, rx);
    if (n > 1) spi_bits(d1, 8, rx);
    spi_end();
  endtask

  task automatic pop_compare(input logic [7:0] rx, input string nm);
    logic [7:0] exp_b;
    checks++;
    if (rd_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %h, required nothing queued", nm, rx);
    end else begin
      exp_b = rd_q.pop_front();
      if (rx !== exp_b) begin
        errors++;
        $display("FAIL %s: got miso byte %h, required %h", nm, rx, exp_b);
      end
    end
  endtask

  task automatic do_read(input logic [23:0] a, input int n, input string nm);
    logic [7:0] rx;
    logic [7:0] hdr;
    spi_begin();
    spi_bits(8'h03, 8, rx);    hdr = rx;
    spi_bits(a[23:16], 8, rx); hdr |= rx;
    spi_bits(a[15:8], 8, rx);  hdr |= rx;
    spi_bits(a[7:0], 8, rx);   hdr |= rx;
    checks++;
    if (hdr !== 8'h00) begin
      errors++;
      $display("FAIL %s_hdr_miso: got %h, required 00", nm, hdr);
    end
    for (int i = 0; i < n; i++) begin
      spi_bits(8'h00, 8, rx);
      pop_compare(rx, nm);
    end
    spi_end();
  endtask

  task automatic do_rdsr(input int n, input string nm);
    logic [7:0] rx;
    spi_begin();
    spi_bits(8'h05, 8, rx);
    checks++;
    if (rx !== 8'h00) begin
      errors++;
      $display("FAIL %s_cmd_miso: got %h, required 00", nm, rx);
    end
    for (int i = 0; i < n; i++) begin
      spi_bits(8'h00, 8, rx);
      pop_compare(rx, nm);
    end
    spi_end();
  endtask

  task automatic check_wel(input logic expv, input string nm);
    checks++;
    if (wel !== expv) begin
      errors++;
      $display("FAIL %s: got o_wel=%b, required %b", nm, wel, expv);
    end
  endtask

  task automatic check_prog_drained(input string nm);
    checks++;
    if (prog_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d program pulses missing, required 0", nm, prog_q.size());
      prog_q.delete();
    end
  endtask

  task automatic test_reset();
    spi.sclk = 1'b0;
    spi.cs_n = 1'b1;
    spi.mosi = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd, cmd_valid, wel, prog_valid, prog_addr, prog_data, spi.miso} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got cmd=%h cv=%b wel=%b pv=%b pa=%h pd=%h miso=%b, required all 0",
               cmd, cmd_valid, wel, prog_valid, prog_addr, prog_data, spi.miso);
    end
  endtask

  task automatic test_pp_wren();
    do_cmd(8'h06);
    check_wel(1'b1, "wren_sets_wel");
    checks++;
    if (last_cmd !== 8'h06) begin
      errors++;
      $display("FAIL wren_cmd: got o_cmd=%h, required 06", last_cmd);
    end
    prog_q.push_back(16'h10A5);
    prog_q.push_back(16'h115A);
    do_pp(24'h000010, 8'hA5, 8'h5A, 2);
    check_prog_drained("pp_pulses_10");
    check_wel(1'b0, "pp_clears_wel");
  endtask

  task automatic test_pp_no_wren();
    do_cmd(8'h06);
    prog_q.push_back(16'h203C);
    do_pp(24'h000020, 8'h3C, 8'h00, 1);
    check_prog_drained("pp_setup_20");
    check_wel(1'b0, "wel_clear_before_pp");
    do_pp(24'h000020, 8'hFF, 8'h00, 1);
    rd_q.push_back(8'h3C);
    do_read(24'h000020, 1, "read_20_unchanged");
  endtask

  task automatic test_read_wrap();
    rd_q.push_back(8'hA5);
    rd_q.push_back(8'h5A);
    do_read(24'h000010, 2, "read_10");
    do_cmd(8'h06);
    prog_q.push_back(16'hFF11);
    prog_q.push_back(16'h0022);
    do_pp(24'h0000FF, 8'h11, 8'h22, 2);
    check_prog_drained("pp_wrap_ff");
    rd_q.push_back(8'h11);
    rd_q.push_back(8'h22);
    do_read(24'h0000FF, 2, "read_wrap_ff");
  endtask

  task automatic test_status();
    do_cmd(8'h06);
    repeat (3) rd_q.push_back(8'h02);
    do_rdsr(3, "rdsr_wel1");
    check_wel(1'b1, "rdsr_keeps_wel");
    do_cmd(8'h04);
    rd_q.push_back(8'h00);
    do_rdsr(1, "rdsr_wel0");
    check_wel(1'b0, "wrdi_clears_wel");
  endtask

  task automatic test_abort();
    logic [7:0] rx0, rx1;
    int         cnt0;
    do_cmd(8'h06);
    check_wel(1'b1, "abort_wren");
    spi_begin();
    spi_bits(8'h02, 8, rx0);
    spi_bits(8'h00, 8, rx0);
    spi_bits(8'h00, 4, rx0);
    spi_end();
    check_wel(1'b0, "abort_pp_clears_wel");
    cnt0 = cmd_cnt;
    spi_begin();
    spi_bits(8'h9F, 8, rx0);
    spi_bits(8'h00, 8, rx1);
    spi_end();
    checks++;
    if (cmd_cnt !== cnt0 + 1 || last_cmd !== 8'h9F) begin
      errors++;
      $display("FAIL unknown_cmd_pulse: got %0d pulses last=%h, required 1 pulse 9F", cmd_cnt - cnt0, last_cmd);
    end
    checks++;
    if ((rx0 | rx1) !== 8'h00) begin
      errors++;
      $display("FAIL unknown_cmd_miso: got %h, required 00", rx0 | rx1);
    end
    rd_q.push_back(8'h22);
    do_read(24'h000000, 1, "read_00_after_abort");
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    do_cmd(8'h06);
    spi_begin();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h30, 8, rx);
    spi_bits(8'h77, 4, rx);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd, cmd_valid, wel, prog_valid, prog_addr, prog_data, spi.miso} !== 29'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got cmd=%h cv=%b wel=%b pv=%b pa=%h pd=%h miso=%b, required all 0",
               cmd, cmd_valid, wel, prog_valid, prog_addr, prog_data, spi.miso);
    end
    rst = 1'b0;
    spi_end();
    check_wel(1'b0, "midrst_wel");
    do_cmd(8'h06);
    prog_q.push_back(16'h3077);
    do_pp(24'h000030, 8'h77, 8'h00, 1);
    check_prog_drained("pp_after_rst");
    rd_q.push_back(8'h77);
    do_read(24'h000030, 1, "read_30_after_rst");
  endtask

  initial begin
    test_reset();
    test_pp_wren();
    test_pp_no_wren();
    test_read_wrap();
    test_status();
    test_abort();
    test_reset_mid();
    check_prog_drained("final_prog_queue");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
